// File: rtl/rip_axi_arbiter.sv
// Two-client line arbiter onto a split AXI-style master: concurrent read and
// write engines, round-robin between fetch and data reads, same-line hazard interlock.
module rip_axi_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 2
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  i_rreq,
    input  logic [ADDR_WIDTH-1:0]                 i_raddr,
    output logic                                  i_rdone,
    input  logic                                  d_rreq,
    input  logic [ADDR_WIDTH-1:0]                 d_raddr,
    output logic                                  d_rdone,
    output logic [DATA_WIDTH*BURST_LEN-1:0]       rdata,
    input  logic                                  d_wreq,
    input  logic [ADDR_WIDTH-1:0]                 d_waddr,
    input  logic [DATA_WIDTH*BURST_LEN-1:0]       d_wdata,
    input  logic [DATA_WIDTH*BURST_LEN/8-1:0]     d_wstrb,
    output logic                                  d_wdone,
    input  logic                                  m_wready,
    output logic [ADDR_WIDTH-1:0]                 m_waddr,
    output logic [DATA_WIDTH*BURST_LEN-1:0]       m_wdata,
    output logic [DATA_WIDTH*BURST_LEN/8-1:0]     m_wstrb,
    output logic                                  m_wvalid,
    input  logic                                  m_wdone,
    input  logic                                  m_rready,
    output logic [ADDR_WIDTH-1:0]                 m_raddr,
    output logic                                  m_rvalid,
    input  logic [DATA_WIDTH*BURST_LEN-1:0]       m_rdata,
    input  logic                                  m_rdone
);

    localparam int unsigned LINE_W = DATA_WIDTH * BURST_LEN;
    localparam int unsigned STRB_W = LINE_W / 8;
    localparam int unsigned OFS    = $clog2(STRB_W);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_e;

    r_state_e                r_state_q, r_state_d;
    w_state_e                w_state_q, w_state_d;
    logic                    r_is_d_q, r_is_d_d;
    logic                    rr_dfirst_q, rr_dfirst_d;
    logic [ADDR_WIDTH-1:0]   m_raddr_q, m_raddr_d;
    logic                    m_rvalid_q, m_rvalid_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    i_rdone_q, i_rdone_d;
    logic                    d_rdone_q, d_rdone_d;
    logic [ADDR_WIDTH-1:0]   m_waddr_q, m_waddr_d;
    logic [LINE_W-1:0]       m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]       m_wstrb_q, m_wstrb_d;
    logic                    m_wvalid_q, m_wvalid_d;
    logic                    d_wdone_q, d_wdone_d;

    logic r_busy_c, w_busy_c, w_grant_c, i_elig_c, d_elig_c, pick_d_c;

    function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH-1:0] x;
        x = a ^ b;
        return (x >> OFS) == '0;
    endfunction

    // In-flight lines block the other engine; a same-cycle write grant wins over a read.
    always_comb begin
        r_busy_c  = (r_state_q == R_ISSUE) || (r_state_q == R_WAIT);
        w_busy_c  = (w_state_q == W_ISSUE) || (w_state_q == W_WAIT);
        w_grant_c = (w_state_q == W_IDLE) && m_wready && d_wreq &&
                    !(r_busy_c && same_line(d_waddr, m_raddr_q));
        i_elig_c  = i_rreq &&
                    !(w_busy_c && same_line(i_raddr, m_waddr_q)) &&
                    !(w_grant_c && same_line(i_raddr, d_waddr));
        d_elig_c  = d_rreq &&
                    !(w_busy_c && same_line(d_raddr, m_waddr_q)) &&
                    !(w_grant_c && same_line(d_raddr, d_waddr));
        pick_d_c  = d_elig_c && (!i_elig_c || rr_dfirst_q);
    end

    // Read engine; the round-robin pointer only moves when both readers contend.
    always_comb begin
        r_state_d   = r_state_q;
        r_is_d_d    = r_is_d_q;
        rr_dfirst_d = rr_dfirst_q;
        m_raddr_d   = m_raddr_q;
        rdata_d     = rdata_q;
        m_rvalid_d  = 1'b0;
        i_rdone_d   = 1'b0;
        d_rdone_d   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (m_rready && (i_elig_c || d_elig_c)) begin
                    r_state_d  = R_ISSUE;
                    r_is_d_d   = pick_d_c;
                    m_raddr_d  = pick_d_c ? d_raddr : i_raddr;
                    m_rvalid_d = 1'b1;
                    if (i_elig_c && d_elig_c) begin
                        rr_dfirst_d = !pick_d_c;
                    end
                end
            end
            R_ISSUE: r_state_d = R_WAIT;
            R_WAIT: begin
                if (m_rdone) begin
                    r_state_d = R_RESP;
                    rdata_d   = m_rdata;
                    i_rdone_d = !r_is_d_q;
                    d_rdone_d = r_is_d_q;
                end
            end
            R_RESP:  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write engine.
    always_comb begin
        w_state_d  = w_state_q;
        m_waddr_d  = m_waddr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        m_wvalid_d = 1'b0;
        d_wdone_d  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_grant_c) begin
                    w_state_d  = W_ISSUE;
                    m_waddr_d  = d_waddr;
                    m_wdata_d  = d_wdata;
                    m_wstrb_d  = d_wstrb;
                    m_wvalid_d = 1'b1;
                end
            end
            W_ISSUE: w_state_d = W_WAIT;
            W_WAIT: begin
                if (m_wdone) begin
                    w_state_d = W_RESP;
                    d_wdone_d = 1'b1;
                end
            end
            W_RESP:  w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            r_is_d_q    <= 1'b0;
            rr_dfirst_q <= 1'b0;
            m_raddr_q   <= '0;
            m_rvalid_q  <= 1'b0;
            rdata_q     <= '0;
            i_rdone_q   <= 1'b0;
            d_rdone_q   <= 1'b0;
            m_waddr_q   <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            m_wvalid_q  <= 1'b0;
            d_wdone_q   <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            r_is_d_q    <= r_is_d_d;
            rr_dfirst_q <= rr_dfirst_d;
            m_raddr_q   <= m_raddr_d;
            m_rvalid_q  <= m_rvalid_d;
            rdata_q     <= rdata_d;
            i_rdone_q   <= i_rdone_d;
            d_rdone_q   <= d_rdone_d;
            m_waddr_q   <= m_waddr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            m_wvalid_q  <= m_wvalid_d;
            d_wdone_q   <= d_wdone_d;
        end
    end

    assign i_rdone  = i_rdone_q;
    assign d_rdone  = d_rdone_q;
    assign d_wdone  = d_wdone_q;
    assign rdata    = rdata_q;
    assign m_raddr  = m_raddr_q;
    assign m_rvalid = m_rvalid_q;
    assign m_waddr  = m_waddr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;
    assign m_wvalid = m_wvalid_q;

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// Directed bench for rip_axi_arbiter with a small latency-programmable master memory.
module tb_rip_axi_arbiter;

    logic        clk, rstn;
    logic        i_rreq, i_rdone, d_rreq, d_rdone, d_wreq, d_wdone;
    logic [31:0] i_raddr, d_raddr, d_waddr, m_waddr, m_raddr;
    logic [63:0] rdata, d_wdata, m_wdata, m_rdata;
    logic [7:0]  d_wstrb, m_wstrb;
    logic        m_wready, m_wvalid, m_wdone, m_rready, m_rvalid, m_rdone;

    rip_axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(2)) dut (
        .clk(clk), .rstn(rstn),
        .i_rreq(i_rreq), .i_raddr(i_raddr), .i_rdone(i_rdone),
        .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rdone(d_rdone),
        .rdata(rdata),
        .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_wdone(d_wdone),
        .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wdone(m_wdone),
        .m_rready(m_rready), .m_raddr(m_raddr), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_rdone(m_rdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks, errors;
    int          rd_lat, wr_lat;
    logic [63:0] mem [16];
    int          rv_cnt, wv_cnt, i_at, dr_at, dw_at, wv_at, quiet;
    int          rv_at [2];
    logic [31:0] rv_addr [2];
    logic [31:0] wv_addr;
    logic [63:0] wv_data, i_data, d_data;
    logic [7:0]  wv_strb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Read side of the master: returns the stored line rd_lat cycles after the command.
    initial begin : rd_master
        logic [31:0] a;
        m_rdone = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_rvalid) begin
                a = m_raddr;
                repeat (rd_lat) @(negedge clk);
                m_rdata = mem[a[6:3]];
                m_rdone = 1'b1;
                @(negedge clk);
                m_rdone = 1'b0;
            end
        end
    end

    // Write side of the master: byte-merges into the line store, owns the preload.
    initial begin : wr_master
        logic [31:0] a;
        logic [63:0] wd;
        logic [7:0]  ws;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        mem[4] = 64'h2020_2020_0000_0020;
        mem[5] = 64'h2828_2828_0000_0028;
        mem[7] = 64'hAAAA_BBBB_CCCC_DDDD;
        mem[8] = 64'h4040_4040_0000_0040;
        m_wdone = 1'b0;
        forever begin
            @(negedge clk);
            if (m_wvalid) begin
                a  = m_waddr;
                wd = m_wdata;
                ws = m_wstrb;
                repeat (wr_lat) @(negedge clk);
                for (int b = 0; b < 8; b++)
                    if (ws[b]) mem[a[6:3]][8*b +: 8] = wd[8*b +: 8];
                m_wdone = 1'b1;
                @(negedge clk);
                m_wdone = 1'b0;
            end
        end
    end

    // Runs the currently raised requests to completion, logging cycle stamps from 1.
    task automatic run(input string tag);
        int n;
        n = 0; rv_cnt = 0; wv_cnt = 0; i_at = -1; dr_at = -1; dw_at = -1; wv_at = -1;
        while ((i_rreq || d_rreq || d_wreq) && n < 100) begin
            @(negedge clk);
            n++;
            if (m_rvalid) begin
                if (rv_cnt < 2) begin
                    rv_at[rv_cnt]   = n;
                    rv_addr[rv_cnt] = m_raddr;
                end
                rv_cnt++;
            end
            if (m_wvalid) begin
                wv_at = n; wv_addr = m_waddr; wv_data = m_wdata; wv_strb = m_wstrb;
                wv_cnt++;
            end
            if (i_rdone) begin i_at  = n; i_data = rdata; i_rreq = 1'b0; end
            if (d_rdone) begin dr_at = n; d_data = rdata; d_rreq = 1'b0; end
            if (d_wdone) begin dw_at = n; d_wreq = 1'b0; end
        end
        check({tag, "_timeout"}, 64'(n < 100), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; rd_lat = 1; wr_lat = 1;
        rstn = 1'b1; m_wready = 1'b1; m_rready = 1'b1;
        i_rreq = 1'b0; d_rreq = 1'b0; d_wreq = 1'b0;
        i_raddr = '0; d_raddr = '0; d_waddr = '0; d_wdata = '0; d_wstrb = '0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valids", 64'({m_rvalid, m_wvalid}), 64'd0);
        check("rst_dones", 64'({i_rdone, d_rdone, d_wdone}), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_raddr", 64'(m_raddr), 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read back the same line.
        d_waddr = 32'h10; d_wdata = 64'h1234_5678_90ab_cdef; d_wstrb = 8'hff; d_wreq = 1'b1;
        run("w10");
        check("w10_wv_cnt", 64'(wv_cnt), 64'd1);
        check("w10_wv_at", 64'(wv_at), 64'd1);
        check("w10_waddr", 64'(wv_addr), 64'h10);
        check("w10_wdata", wv_data, 64'h1234_5678_90ab_cdef);
        check("w10_wstrb", 64'(wv_strb), 64'hff);
        check("w10_done_at", 64'(dw_at), 64'd3);
        check("w10_no_read", 64'(rv_cnt), 64'd0);
        d_raddr = 32'h10; d_rreq = 1'b1;
        run("r10");
        check("r10_rv_cnt", 64'(rv_cnt), 64'd1);
        check("r10_raddr", 64'(rv_addr[0]), 64'h10);
        check("r10_done_at", 64'(dr_at), 64'd3);
        check("r10_data", d_data, 64'h1234_5678_90ab_cdef);
        check("r10_held", rdata, 64'h1234_5678_90ab_cdef);

        // Contending readers: i first after reset, then d first.
        i_raddr = 32'h20; d_raddr = 32'h28; i_rreq = 1'b1; d_rreq = 1'b1;
        run("rr1");
        check("rr1_first", 64'(rv_addr[0]), 64'h20);
        check("rr1_second", 64'(rv_addr[1]), 64'h28);
        check("rr1_i_at", 64'(i_at), 64'd3);
        check("rr1_d_at", 64'(dr_at), 64'd7);
        check("rr1_i_data", i_data, 64'h2020_2020_0000_0020);
        check("rr1_d_data", d_data, 64'h2828_2828_0000_0028);
        i_rreq = 1'b1; d_rreq = 1'b1;
        run("rr2");
        check("rr2_first", 64'(rv_addr[0]), 64'h28);
        check("rr2_second", 64'(rv_addr[1]), 64'h20);
        check("rr2_d_at", 64'(dr_at), 64'd3);
        check("rr2_i_at", 64'(i_at), 64'd7);
        i_rreq = 1'b1; d_rreq = 1'b1;
        run("rr3");
        check("rr3_first", 64'(rv_addr[0]), 64'h20);

        // Same-line write and read: write wins, read follows with merged data.
        d_waddr = 32'h38; d_wdata = 64'h1111_2222_3333_4444; d_wstrb = 8'h0f; d_wreq = 1'b1;
        d_raddr = 32'h3c; d_rreq = 1'b1;
        run("haz");
        check("haz_wv_at", 64'(wv_at), 64'd1);
        check("haz_wdone_at", 64'(dw_at), 64'd3);
        check("haz_rv_at", 64'(rv_at[0]), 64'd4);
        check("haz_raddr", 64'(rv_addr[0]), 64'h3c);
        check("haz_rdone_at", 64'(dr_at), 64'd6);
        check("haz_data", d_data, 64'hAAAA_BBBB_3333_4444);

        // Different lines: both commands in the same cycle.
        d_waddr = 32'h30; d_wdata = 64'h0000_0000_0000_0030; d_wstrb = 8'hff; d_wreq = 1'b1;
        i_raddr = 32'h40; i_rreq = 1'b1;
        run("par");
        check("par_wv_at", 64'(wv_at), 64'd1);
        check("par_rv_at", 64'(rv_at[0]), 64'd1);
        check("par_i_at", 64'(i_at), 64'd3);
        check("par_w_at", 64'(dw_at), 64'd3);
        check("par_i_data", i_data, 64'h4040_4040_0000_0040);

        // Reset while a read is outstanding.
        rd_lat = 6;
        d_raddr = 32'h50; d_rreq = 1'b1;
        @(negedge clk);
        check("rst2_rvalid", 64'(m_rvalid), 64'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst2_raddr", 64'(m_raddr), 64'd0);
        check("rst2_rdata", rdata, 64'd0);
        check("rst2_wcmd", {m_waddr, m_wstrb, 24'd0}, 64'd0);
        check("rst2_wdata", m_wdata, 64'd0);
        d_rreq = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (i_rdone || d_rdone || m_rvalid) quiet++;
        end
        check("rst2_no_done", 64'(quiet), 64'd0);
        rd_lat = 1;
        i_raddr = 32'h20; d_raddr = 32'h10; i_rreq = 1'b1; d_rreq = 1'b1;
        run("post");
        check("post_first", 64'(rv_addr[0]), 64'h20);
        check("post_i_at", 64'(i_at), 64'd3);
        check("post_d_at", 64'(dr_at), 64'd7);
        check("post_d_data", d_data, 64'h1234_5678_90ab_cdef);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no_finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/rip_axi_arbiter.md
RIP_AXI_ARBITER -- requirements
Module: rip_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI beat width.
REQ-003 SHALL have parameter BURST_LEN, default 2, beats per line; LINE_W = DATA_WIDTH*BURST_LEN, STRB_W = LINE_W/8, OFS = log2(STRB_W).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk, rstn.
REQ-005 SHALL have ports (name  dir  width  meaning):
 clk  in  1  clock
 rstn  in  1  async reset, active low
 i_rreq  in  1  instruction-fetch line read request (level)
 i_raddr  in  ADDR_WIDTH  fetch address
 i_rdone  out  1  fetch complete pulse
 d_rreq  in  1  data line read request (level)
 d_raddr  in  ADDR_WIDTH  data read address
 d_rdone  out  1  data read complete pulse
 rdata  out  LINE_W  read line, valid with i_rdone/d_rdone
 d_wreq  in  1  data line write request (level)
 d_waddr  in  ADDR_WIDTH  write address
 d_wdata  in  LINE_W  write line
 d_wstrb  in  STRB_W  byte enables
 d_wdone  out  1  write complete pulse
 m_wready  in  1  master write path idle
 m_waddr / m_wdata / m_wstrb  out  ADDR_WIDTH / LINE_W / STRB_W  write command
 m_wvalid  out  1  write command strobe
 m_wdone  in  1  master write complete pulse
 m_rready  in  1  master read path idle
 m_raddr  out  ADDR_WIDTH  read command address
 m_rvalid  out  1  read command strobe
 m_rdata  in  LINE_W  master read line
 m_rdone  in  1  master read complete pulse

Function
REQ-006 Clients SHALL hold req and address/data stable until their done pulse; req low from the cycle after done.
REQ-007 Read FSM SHALL have states R_IDLE, R_ISSUE, R_WAIT, R_RESP.
REQ-008 R_IDLE -> R_ISSUE when m_rready=1 and an eligible read req exists; latch owner and address.
REQ-009 Both read reqs eligible: grant port not granted last (round-robin); after reset, i port first.
REQ-010 R_ISSUE: m_rvalid=1 for exactly one cycle with m_raddr = latched address (unmodified, not aligned) -> R_WAIT.
REQ-011 R_WAIT: on m_rdone register m_rdata into rdata -> R_RESP; m_rdone in any other state ignored.
REQ-012 R_RESP: owner's done=1 one cycle, rdata held until next read response -> R_IDLE; grant-to-done latency = master latency + 2 cycles.
REQ-013 Write FSM SHALL have states W_IDLE, W_ISSUE, W_WAIT, W_RESP, same timing as read: m_wvalid one cycle, d_wdone one cycle after m_wdone.
REQ-014 Hazard: read req ineligible while write FSM is in W_ISSUE/W_WAIT and addr[ADDR_WIDTH-1:OFS] equals in-flight write line; write req blocked likewise against an in-flight read line.
REQ-015 Same-cycle read and write eligible on the same line: write wins, read waits until W_RESP; different lines: both issue in same cycle.
REQ-016 Read and write FSMs SHALL run concurrently; at most one outstanding read and one outstanding write.
REQ-017 Request dropped before grant SHALL be ignored; after grant the transaction completes regardless of req.

Reset
REQ-018 rstn=0 SHALL asynchronously force both FSMs to IDLE, round-robin to i port, and all outputs (m_rvalid, m_wvalid, dones, m_raddr, m_waddr, m_wdata, m_wstrb, rdata) to 0; in-flight transactions discarded, no done emitted.

Verification
REQ-019 d_wreq 0x10, data 0x1234567890abcdef, strb 0xff -> one m_wvalid, d_wdone after m_wdone; then d_rreq 0x10 -> rdata 0x1234567890abcdef.
REQ-020 i_rreq 0x20 and d_rreq 0x28 same cycle -> i served first, d second; repeat -> d first.
REQ-021 d_wreq 0x38 and d_rreq 0x3c same cycle -> read issued only after d_wdone, returns written data.
REQ-022 d_wreq 0x30 and i_rreq 0x40 same cycle -> m_wvalid and m_rvalid in same cycle.
REQ-023 rstn low during R_WAIT -> outputs 0 immediately, no i_rdone/d_rdone, next request after reset served normally.
